// File: rtl/mem_net_arbiter.sv
// Round-robin arbiter sharing one downstream memory request/response channel among
// NUM_REQ requesters; an in-flight ID FIFO steers in-order responses back to the issuer.
`timescale 1ns/1ps
module mem_net_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int REQ_W    = 81,
  parameter int RESP_W   = 48,
  parameter int MAX_INFL = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_val,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ*REQ_W-1:0]   req_msg,
  output logic                       mem_val,
  input  logic                       mem_rdy,
  output logic [REQ_W-1:0]           mem_msg,
  input  logic                       mresp_val,
  output logic                       mresp_rdy,
  input  logic [RESP_W-1:0]          mresp_msg,
  output logic [NUM_REQ-1:0]         resp_val,
  input  logic [NUM_REQ-1:0]         resp_rdy,
  output logic [RESP_W-1:0]          resp_msg,
  output logic                       err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_INFL > 1) ? $clog2(MAX_INFL) : 1;
  localparam int CNT_W = $clog2(MAX_INFL) + 1;

  typedef logic [ID_W-1:0] id_t;
  typedef enum logic {ST_ARB, ST_HOLD} state_e;

  state_e           state_q, state_d;
  id_t              ptr_q, ptr_d;
  id_t              lock_q, lock_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  id_t              fifo_mem [MAX_INFL];

  logic full, empty, any_val, arb_found, push, pop;
  id_t  arb_grant, grant, head;

  function automatic id_t rr_index(input id_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return id_t'(s);
  endfunction

  // Full is taken from the registered count only, so a same-cycle response pop
  // never feeds back into the request path.
  assign full  = (count_q == CNT_W'(MAX_INFL));
  assign empty = (count_q == '0);
  assign head  = fifo_mem[rd_ptr_q];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    arb_grant = ptr_q;
    arb_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_val[rr_index(ptr_q, i)]) begin
        arb_grant = rr_index(ptr_q, i);
        arb_found = 1'b1;
      end
    end
  end

  // A stalled grant is locked so mem_msg stays stable until the transfer completes.
  assign grant   = (state_q == ST_HOLD) ? lock_q : arb_grant;
  assign any_val = (state_q == ST_HOLD) ? req_val[lock_q] : arb_found;
  assign mem_msg = req_msg[int'(grant)*REQ_W +: REQ_W];
  assign resp_msg = mresp_msg;
  assign err      = err_q;

  always_comb begin
    req_rdy        = '0;
    req_rdy[grant] = rst_n & mem_rdy & ~full;
    mem_val        = rst_n & any_val & ~full;
    resp_val       = '0;
    resp_val[head] = rst_n & mresp_val & ~empty;
    mresp_rdy      = rst_n & resp_rdy[head] & ~empty;
  end

  assign push = mem_val & mem_rdy;
  assign pop  = mresp_val & mresp_rdy;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      ST_ARB: begin
        if (mem_val && !mem_rdy) begin
          state_d = ST_HOLD;
          lock_d  = grant;
        end
      end
      ST_HOLD: begin
        if (push) begin
          state_d = ST_ARB;
        end else if (!req_val[lock_q]) begin
          state_d = ST_ARB;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (push) begin
      ptr_d    = (grant == id_t'(NUM_REQ - 1)) ? '0 : grant + id_t'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (mresp_val && empty) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARB;
      ptr_q    <= '0;
      lock_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the ID storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_mem_net_arbiter.sv
// Directed bench for mem_net_arbiter: stimulus pushes expected transfers into queues,
// a negedge monitor pops and compares whenever a request or response handshake fires.
`timescale 1ns/1ps
module tb_mem_net_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int REQ_W    = 81;
  localparam int RESP_W   = 48;
  localparam int MAX_INFL = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_val, req_rdy, resp_val, resp_rdy;
  logic [NUM_REQ*REQ_W-1:0] req_msg;
  logic                     mem_val, mem_rdy, mresp_val, mresp_rdy, err;
  logic [REQ_W-1:0]         mem_msg;
  logic [RESP_W-1:0]        mresp_msg, resp_msg;

  typedef struct {
    int                id;
    logic [RESP_W-1:0] msg;
  } resp_exp_t;

  logic [REQ_W-1:0] exp_req_q [$];
  resp_exp_t        exp_resp_q [$];
  resp_exp_t        re;
  logic [1:0]       oh;
  int n_cmp = 0;
  int n_bad = 0;

  mem_net_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .RESP_W(RESP_W), .MAX_INFL(MAX_INFL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .mem_val(mem_val), .mem_rdy(mem_rdy), .mem_msg(mem_msg),
    .mresp_val(mresp_val), .mresp_rdy(mresp_rdy), .mresp_msg(mresp_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_val && mem_rdy) begin
      if (exp_req_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL req_unexpected: got %0h expected no transfer", mem_msg);
      end else begin
        check("req_msg", mem_msg, exp_req_q.pop_front());
      end
    end
    if (rst_n && ((resp_val & resp_rdy) != '0)) begin
      if (exp_resp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_unexpected: got resp_val %0b expected none", resp_val);
      end else begin
        re = exp_resp_q.pop_front();
        oh = 2'b01 << re.id;
        check("resp_dest", resp_val, oh);
        check("resp_msg", resp_msg, re.msg);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_msg(input int r, input logic [REQ_W-1:0] m);
    req_msg[r*REQ_W +: REQ_W] = m;
  endtask

  // Single requester r presents m with mem_rdy=1; one transfer expected.
  task automatic issue(input int r, input logic [REQ_W-1:0] m);
    req_val = 2'b01 << r; mem_rdy = 1'b1; set_msg(r, m);
    exp_req_q.push_back(m);
    sample(); step();
    req_val = '0;
  endtask

  task automatic respond(input int id, input logic [RESP_W-1:0] m);
    mresp_val = 1'b1; resp_rdy = 2'b11; mresp_msg = m;
    exp_resp_q.push_back('{id: id, msg: m});
    sample(); step();
    mresp_val = 1'b0;
  endtask

  // Both requesters valid every cycle; messages encode cycle and requester.
  task automatic issue_both(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      req_val = 2'b11; mem_rdy = 1'b1;
      set_msg(0, REQ_W'(base + k*16));
      set_msg(1, REQ_W'(base + k*16 + 1));
      exp_req_q.push_back(REQ_W'(base + k*16 + (k % 2)));
      sample(); step();
    end
    req_val = '0;
  endtask

  initial begin
    req_val = 2'b11; mem_rdy = 1'b1; req_msg = '0;
    mresp_val = 1'b1; mresp_msg = '0; resp_rdy = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_val", mem_val, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_mresp_rdy", mresp_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1; req_val = '0; mresp_val = 1'b0; mem_rdy = 1'b0;
    sample();
    check("post_rst_err", err, 0);
    step();

    // 1: alternating grants, responses back to their issuers
    issue_both('h100, 4);
    for (int k = 0; k < 4; k++) respond(k % 2, RESP_W'('hA0 + k));

    // 2: stalled grant to req0 stays locked while req1 (now higher priority) asserts
    issue(0, 'h200);
    req_val = 2'b01; mem_rdy = 1'b0; set_msg(0, 'h201); set_msg(1, 'h2F1);
    sample();
    check("hold_mem_val", mem_val, 1);
    check("hold_msg_c0", mem_msg, 'h201);
    step();
    for (int c = 1; c <= 2; c++) begin
      req_val = 2'b11;
      sample();
      check("hold_msg", mem_msg, 'h201);
      check("hold_req_rdy", req_rdy, 2'b00);
      step();
    end
    mem_rdy = 1'b1; exp_req_q.push_back('h201);
    sample();
    check("hold_release_rdy", req_rdy, 2'b01);
    step();
    req_val = 2'b10; exp_req_q.push_back('h2F1);
    sample(); step();
    req_val = '0;
    respond(0, 'hB0); respond(0, 'hB1); respond(1, 'hB2);

    // 3: capacity limit; a same-cycle pop does not unblock the waiting request
    for (int k = 0; k < 4; k++) issue(0, REQ_W'('h300 + k));
    req_val = 2'b01; mem_rdy = 1'b1; set_msg(0, 'h304);
    sample();
    check("full_mem_val", mem_val, 0);
    check("full_req_rdy", req_rdy, 2'b00);
    step();
    mresp_val = 1'b1; resp_rdy = 2'b11; mresp_msg = 'hC0;
    exp_resp_q.push_back('{id: 0, msg: 48'hC0});
    sample();
    check("full_pop_mem_val", mem_val, 0);
    step();
    mresp_val = 1'b0; exp_req_q.push_back('h304);
    sample();
    check("unblocked_mem_val", mem_val, 1);
    step();
    req_val = '0;
    for (int k = 1; k <= 4; k++) respond(0, RESP_W'('hC0 + k));

    // 4: head owner not ready holds the response
    issue(1, 'h400);
    mresp_val = 1'b1; mresp_msg = 'hD0; resp_rdy = 2'b01;
    for (int c = 0; c < 2; c++) begin
      sample();
      check("blocked_mresp_rdy", mresp_rdy, 0);
      check("blocked_resp_val", resp_val, 2'b10);
      step();
    end
    resp_rdy = 2'b11; exp_resp_q.push_back('{id: 1, msg: 48'hD0});
    sample();
    check("unblocked_mresp_rdy", mresp_rdy, 1);
    step();
    mresp_val = 1'b0;

    // 5: simultaneous push and pop at count 2, then error on response with empty FIFO
    issue(1, 'h500);
    issue(0, 'h501);
    req_val = 2'b10; mem_rdy = 1'b1; set_msg(1, 'h502); exp_req_q.push_back('h502);
    mresp_val = 1'b1; resp_rdy = 2'b11; mresp_msg = 'hE0;
    exp_resp_q.push_back('{id: 1, msg: 48'hE0});
    sample();
    check("pushpop_mem_val", mem_val, 1);
    check("pushpop_mresp_rdy", mresp_rdy, 1);
    step();
    mresp_val = 1'b0;
    issue(0, 'h503);
    issue(1, 'h504);
    req_val = 2'b01; set_msg(0, 'h505);
    sample();
    check("count_after_pushpop_full", mem_val, 0);
    step();
    req_val = '0;
    for (int k = 1; k <= 4; k++) respond((k - 1) % 2, RESP_W'('hE0 + k));
    sample();
    check("err_before_stray", err, 0);
    step();
    mresp_val = 1'b1; mresp_msg = 'hEE;
    sample();
    check("stray_mresp_rdy", mresp_rdy, 0);
    check("stray_resp_val", resp_val, 2'b00);
    step();
    mresp_val = 1'b0;
    sample();
    check("err_set", err, 1);
    repeat (3) step();
    sample();
    check("err_sticky", err, 1);
    step();

    // 6: reset while holding with 3 in flight
    issue(0, 'h600);
    issue(1, 'h601);
    issue(0, 'h602);
    req_val = 2'b01; mem_rdy = 1'b0; set_msg(0, 'h6FF);
    sample();
    check("pre_rst_hold_val", mem_val, 1);
    step();
    mresp_val = 1'b1; resp_rdy = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_val", mem_val, 0);
    check("midrst_req_rdy", req_rdy, 0);
    check("midrst_resp_val", resp_val, 0);
    check("midrst_mresp_rdy", mresp_rdy, 0);
    check("midrst_err", err, 0);
    step();
    rst_n = 1'b1; mresp_val = 1'b0; req_val = '0;
    issue_both('h700, 4);
    req_val = 2'b01; mem_rdy = 1'b1; set_msg(0, 'h7FF);
    sample();
    check("post_rst_count_full", mem_val, 0);
    check("post_rst_err", err, 0);
    step();
    req_val = '0;
    for (int k = 0; k < 4; k++) respond(k % 2, RESP_W'('hF0 + k));

    sample();
    check("exp_req_drained", exp_req_q.size(), 0);
    check("exp_resp_drained", exp_resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
